// File: rtl/vec_wb_buffer.sv
// Vector writeback buffer: masks/tails each lane group, queues it in a FIFO
// and presents it first-word-fall-through to the vector register file port.
module vec_wb_buffer #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int VECTOR_LANES = 8,
    parameter  int DEPTH        = 4,
    localparam int VLW          = $clog2(32 * VECTOR_LANES) + 1,
    localparam int PW           = $clog2(DEPTH),
    localparam int CW           = PW + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush_i,
    input  logic                               grp_valid_i,
    output logic                               grp_ready_o,
    input  logic [VECTOR_LANES-1:0]            lane_ready_i,
    input  logic [DATA_WIDTH*VECTOR_LANES-1:0] lane_result_i,
    input  logic [VECTOR_LANES-1:0]            mask_i,
    input  logic                               vm_i,
    input  logic [VLW-1:0]                     vl_i,
    input  logic [4:0]                         grp_idx_i,
    input  logic [4:0]                         vd_i,
    input  logic                               last_i,
    output logic                               wb_valid_o,
    input  logic                               wb_ready_i,
    output logic [DATA_WIDTH*VECTOR_LANES-1:0] wb_data_o,
    output logic [VECTOR_LANES-1:0]            wb_we_o,
    output logic [4:0]                         wb_vd_o,
    output logic [4:0]                         wb_grp_o,
    output logic                               done_o,
    output logic                               err_o
);

    typedef struct packed {
        logic [DATA_WIDTH*VECTOR_LANES-1:0] data;
        logic [VECTOR_LANES-1:0]            we;
        logic [4:0]                         vd;
        logic [4:0]                         grp;
        logic                               last;
    } entry_t;

    entry_t                  mem_q [DEPTH];
    entry_t                  head;
    logic [PW-1:0]           wptr_q, wptr_d;
    logic [PW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    push, pop;
    logic [VECTOR_LANES-1:0] en;
    logic [VLW-1:0]          base;

    assign grp_ready_o = (cnt_q != CW'(DEPTH));
    assign wb_valid_o  = (cnt_q != '0);
    assign push        = grp_valid_i & grp_ready_o;
    assign pop         = wb_valid_o & wb_ready_i;
    assign head        = mem_q[rptr_q];

    // Element index of lane l is grp_idx*LANES + l; at or beyond vl is tail.
    always_comb begin
        base = VLW'(grp_idx_i) * VLW'(VECTOR_LANES);
        en   = '0;
        for (int l = 0; l < VECTOR_LANES; l++) begin
            en[l] = (vm_i | mask_i[l]) & ((base + VLW'(l)) < vl_i);
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        done_d = 1'b0;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            err_d  = err_q | (push & |(en & ~lane_ready_i));
            done_d = pop & head.last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end

    // Storage needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem_q[wptr_q] <= '{data: lane_result_i,
                               we:   en & lane_ready_i,
                               vd:   vd_i,
                               grp:  grp_idx_i,
                               last: last_i};
        end
    end

    assign wb_data_o = wb_valid_o ? head.data : '0;
    assign wb_we_o   = wb_valid_o ? head.we   : '0;
    assign wb_vd_o   = wb_valid_o ? head.vd   : '0;
    assign wb_grp_o  = wb_valid_o ? head.grp  : '0;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_vec_wb_buffer.sv
// Bench for vec_wb_buffer: queue-based reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_vec_wb_buffer;

    localparam int DW = 32;
    localparam int NL = 8;
    localparam int DEPTH = 4;

    logic            clk = 0;
    logic            rst;
    logic            flush_i;
    logic            grp_valid_i;
    logic            grp_ready_o;
    logic [NL-1:0]   lane_ready_i;
    logic [DW*NL-1:0] lane_result_i;
    logic [NL-1:0]   mask_i;
    logic            vm_i;
    logic [8:0]      vl_i;
    logic [4:0]      grp_idx_i;
    logic [4:0]      vd_i;
    logic            last_i;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [DW*NL-1:0] wb_data_o;
    logic [NL-1:0]   wb_we_o;
    logic [4:0]      wb_vd_o;
    logic [4:0]      wb_grp_o;
    logic            done_o;
    logic            err_o;

    int checks = 0;
    int errors = 0;

    vec_wb_buffer #(.DATA_WIDTH(DW), .VECTOR_LANES(NL), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .grp_valid_i(grp_valid_i), .grp_ready_o(grp_ready_o),
        .lane_ready_i(lane_ready_i), .lane_result_i(lane_result_i),
        .mask_i(mask_i), .vm_i(vm_i), .vl_i(vl_i),
        .grp_idx_i(grp_idx_i), .vd_i(vd_i), .last_i(last_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_data_o(wb_data_o), .wb_we_o(wb_we_o), .wb_vd_o(wb_vd_o),
        .wb_grp_o(wb_grp_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW*NL-1:0] d;
        logic [NL-1:0]    we;
        logic [4:0]       vd;
        logic [4:0]       grp;
        logic             last;
    } ent_t;

    ent_t mq[$];
    ent_t ne;
    ent_t hd;
    logic m_err = 0;
    logic m_done = 0;
    bit   mpush, mpop;

    // Reference model: a plain queue of accepted groups.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_err = 0;
            m_done = 0;
        end else begin
            mpush = grp_valid_i && (mq.size() != DEPTH);
            mpop = wb_ready_i && (mq.size() != 0);
            if (flush_i) begin
                mq.delete();
                m_err = 0;
                m_done = 0;
            end else begin
                m_done = mpop && mq[0].last;
                if (mpop) void'(mq.pop_front());
                if (mpush) begin
                    ne.d = lane_result_i;
                    ne.vd = vd_i;
                    ne.grp = grp_idx_i;
                    ne.last = last_i;
                    for (int l = 0; l < NL; l++) begin
                        bit act;
                        act = (vm_i || mask_i[l]) &&
                              (int'(grp_idx_i) * NL + l < int'(vl_i));
                        ne.we[l] = act && lane_ready_i[l];
                        if (act && !lane_ready_i[l]) m_err = 1;
                    end
                    mq.push_back(ne);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mq.size() != 0) hd = mq[0];
            else hd = '{d: '0, we: '0, vd: '0, grp: '0, last: 1'b0};
            chk("grp_ready", 256'(grp_ready_o), 256'(mq.size() != DEPTH));
            chk("wb_valid", 256'(wb_valid_o), 256'(mq.size() != 0));
            chk("wb_data", 256'(wb_data_o), 256'(hd.d));
            chk("wb_we", 256'(wb_we_o), 256'(hd.we));
            chk("wb_vd", 256'(wb_vd_o), 256'(hd.vd));
            chk("wb_grp", 256'(wb_grp_o), 256'(hd.grp));
            chk("done", 256'(done_o), 256'(m_done));
            chk("err", 256'(err_o), 256'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_grp(input logic [4:0] g, input logic [7:0] base,
                           input logic lst);
        grp_idx_i = g;
        vd_i = 5'd3;
        last_i = lst;
        for (int l = 0; l < NL; l++)
            lane_result_i[l*DW +: DW] = 32'(base) + 32'(l);
    endtask

    initial begin
        rst = 1;
        flush_i = 0;
        grp_valid_i = 0;
        lane_ready_i = 8'hFF;
        lane_result_i = '0;
        mask_i = '0;
        vm_i = 1;
        vl_i = 9'd8;
        grp_idx_i = 0;
        vd_i = 0;
        last_i = 0;
        wb_ready_i = 0;
        #22;
        rst = 0;
        step();
        chk("rst_ready", 256'(grp_ready_o), 256'(1));
        chk("rst_valid", 256'(wb_valid_o), 256'(0));
        chk("rst_err", 256'(err_o), 256'(0));

        // Basic path
        set_grp(0, 8'h1, 1);
        wb_ready_i = 1;
        grp_valid_i = 1;
        step();
        grp_valid_i = 0;
        chk("basic_valid", 256'(wb_valid_o), 256'(1));
        chk("basic_we", 256'(wb_we_o), 256'(8'hFF));
        chk("basic_lane3", 256'(wb_data_o[3*DW +: DW]), 256'(32'h4));
        chk("basic_lane7", 256'(wb_data_o[7*DW +: DW]), 256'(32'h8));
        step();
        chk("basic_done", 256'(done_o), 256'(1));
        step();
        chk("basic_done_once", 256'(done_o), 256'(0));

        // Mask and tail
        wb_ready_i = 0;
        vm_i = 0;
        mask_i = 8'hA5;
        vl_i = 9'd13;
        set_grp(1, 8'h10, 0);
        grp_valid_i = 1;
        step();
        grp_valid_i = 0;
        chk("mask_tail_we", 256'(wb_we_o), 256'(8'h05));
        wb_ready_i = 1;
        step();
        wb_ready_i = 0;
        vm_i = 1;
        vl_i = 9'd255;

        // Full and backpressure
        for (int g = 0; g < 4; g++) begin
            set_grp(5'(g), 8'(8'h20 + 8'(g) * 8'h10), 0);
            grp_valid_i = 1;
            step();
        end
        chk("full_ready", 256'(grp_ready_o), 256'(0));
        set_grp(4, 8'h70, 0);
        step();
        chk("full_refuse", 256'(grp_ready_o), 256'(0));
        chk("full_head0", 256'(wb_grp_o), 256'(0));
        wb_ready_i = 1;
        step();
        chk("pop_head1", 256'(wb_grp_o), 256'(1));
        chk("slot_free", 256'(grp_ready_o), 256'(1));
        step();
        grp_valid_i = 0;
        for (int g = 2; g < 5; g++) begin
            chk("order", 256'(wb_grp_o), 256'(g));
            step();
        end
        chk("drained", 256'(wb_valid_o), 256'(0));

        // Steady streaming at count=1
        vl_i = 9'd8;
        set_grp(0, 8'h80, 0);
        grp_valid_i = 1;
        step();
        for (int i = 1; i <= 10; i++) begin
            set_grp(5'(i), 8'(8'h80 + 8'(i)), 0);
            step();
            chk("stream_grp", 256'(wb_grp_o), 256'(i));
            chk("stream_ready", 256'(grp_ready_o), 256'(1));
        end
        grp_valid_i = 0;
        step();
        chk("stream_empty", 256'(wb_valid_o), 256'(0));

        // Error and flush
        wb_ready_i = 0;
        lane_ready_i = 8'hFE;
        set_grp(0, 8'h90, 1);
        grp_valid_i = 1;
        step();
        grp_valid_i = 0;
        lane_ready_i = 8'hFF;
        chk("err_set", 256'(err_o), 256'(1));
        chk("err_we", 256'(wb_we_o), 256'(8'hFE));
        flush_i = 1;
        wb_ready_i = 1;
        step();
        flush_i = 0;
        chk("flush_err", 256'(err_o), 256'(0));
        chk("flush_valid", 256'(wb_valid_o), 256'(0));
        chk("flush_done", 256'(done_o), 256'(0));
        step();
        chk("flush_done2", 256'(done_o), 256'(0));

        // vl=0: group fully disabled but still queued with last
        vl_i = 9'd0;
        set_grp(0, 8'hA0, 1);
        wb_ready_i = 0;
        grp_valid_i = 1;
        step();
        grp_valid_i = 0;
        chk("vl0_valid", 256'(wb_valid_o), 256'(1));
        chk("vl0_we", 256'(wb_we_o), 256'(0));
        chk("vl0_err", 256'(err_o), 256'(0));
        wb_ready_i = 1;
        step();
        chk("vl0_done", 256'(done_o), 256'(1));
        vl_i = 9'd8;

        // Async reset with 3 groups queued
        wb_ready_i = 0;
        for (int g = 0; g < 3; g++) begin
            set_grp(5'(g), 8'hB0, 1);
            grp_valid_i = 1;
            step();
        end
        grp_valid_i = 0;
        chk("pre_rst_valid", 256'(wb_valid_o), 256'(1));
        #1;
        rst = 1;
        #1;
        chk("arst_valid", 256'(wb_valid_o), 256'(0));
        chk("arst_ready", 256'(grp_ready_o), 256'(1));
        chk("arst_grp", 256'(wb_grp_o), 256'(0));
        wb_ready_i = 1;
        step();
        rst = 0;
        step();
        chk("post_rst_done", 256'(done_o), 256'(0));
        step();
        chk("post_rst_valid", 256'(wb_valid_o), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_wb_buffer.md
Name: vec_wb_buffer

Overview:
- Writeback stage directly downstream of the VECTOR_LANES parallel valu lanes.
- Each cycle it captures one element group: the per-lane results, lane-ready flags and the group metadata.
- Per element, it applies the v0 mask and the vl tail cutoff, then queues the group in a small FIFO.
- It presents groups to the vector register file write port over a valid/ready handshake, producing per-element write enables, a completion pulse and a sticky error flag.

Parameters:
DATA_WIDTH, 32, element/lane width in bits
VECTOR_LANES, 8, lanes (elements) per group
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
flush_i  input  1  synchronous clear of FIFO and error flag
grp_valid_i  input  1  group present on lane inputs
grp_ready_o  output  1  buffer can accept a group this cycle
lane_ready_i  input  VECTOR_LANES  per-lane ready_res from valu
lane_result_i  input  DATA_WIDTH*VECTOR_LANES  lane l at bits [l*DATA_WIDTH +: DATA_WIDTH]
mask_i  input  VECTOR_LANES  v0 mask bits for this group
vm_i  input  1  1 = unmasked instruction (mask_i ignored)
vl_i  input  $clog2(32*VECTOR_LANES)+1  active vector length in elements
grp_idx_i  input  5  element-group index within the instruction
vd_i  input  5  destination vector register
last_i  input  1  final group of the instruction
wb_valid_o  output  1  head entry valid
wb_ready_i  input  1  VRF accepts head entry
wb_data_o  output  DATA_WIDTH*VECTOR_LANES  head results
wb_we_o  output  VECTOR_LANES  per-element write enable
wb_vd_o  output  5  head destination register
wb_grp_o  output  5  head group index
done_o  output  1  one-cycle pulse when a last_i group is popped
err_o  output  1  sticky: an active lane lacked lane_ready

Behaviour:
- Reset values (rst=1, asynchronous): write pointer, read pointer and count = 0. wb_valid_o=0, grp_ready_o=1, done_o=0, err_o=0. wb_data_o, wb_we_o, wb_vd_o and wb_grp_o = 0.
- Reset asserted mid-operation discards all queued groups immediately; no writeback completes.
- grp_ready_o = (count != DEPTH). It is a function of registered count only, never of wb_ready_i.
- Push: grp_valid_i & grp_ready_o.
- Per-lane element enable at push:
  - en[l] = (vm_i | mask_i[l]) & (grp_idx_i*VECTOR_LANES + l < vl_i).
  - The sum is computed at vl_i width, with no overflow for legal inputs.
- Stored per entry: results, we = en & lane_ready_i, vd, grp_idx, last.
- Error: on push, if any lane has en[l]=1 and lane_ready_i[l]=0, then err_o <= 1. err_o holds until rst or flush_i.
- Pop: wb_valid_o & wb_ready_i.
- Output is first-word-fall-through from the FIFO head.
  - A group pushed into an empty FIFO in cycle N appears with wb_valid_o=1 in cycle N+1.
  - wb_valid_o = (count != 0).
  - wb_* outputs are 0 when the FIFO is empty.
- Groups are popped in push order. Pointers wrap modulo DEPTH.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- Full with a pop in the same cycle: the push is refused (grp_ready_o=0 that cycle). The freed slot is visible next cycle.
- Empty: no pop is possible. A push does not bypass to the output in the same cycle.
- A group with all wb_we_o = 0 (fully masked or tail) is still queued and popped, so last_i and done_o are preserved.
- done_o: registered; asserted in the cycle after popping an entry with last=1, for exactly one cycle.
- flush_i:
  - Next cycle: count=0, pointers=0, err_o=0, wb_valid_o=0, done_o=0.
  - Flush has priority over a same-cycle push or pop, which are both discarded.
  - A pop coinciding with flush_i does not produce done_o.
- wb_ready_i asserted while wb_valid_o=0 has no effect.
- vl_i=0: every element is disabled, and the group is still queued.

Test Plan:
- Basic path:
  - Stimulus: one group with vm_i=1, vl_i=8, grp_idx=0, all lane_ready=1, results 0x1..0x8, last=1, wb_ready_i=1.
  - Response: in the next cycle wb_valid_o=1, wb_we_o=0xFF, data lane l=l+1; done_o pulses one cycle later.
- Mask and tail:
  - Stimulus: vm_i=0, mask_i=0xA5, vl_i=13, grp_idx=1.
  - Response: wb_we_o = 0xA5 & 0x1F = 0x05.
- Full and backpressure:
  - Stimulus: wb_ready_i=0; push 4 groups, offer a 5th.
  - Response: grp_ready_o=0 after the 4th push and the 5th is not accepted.
  - Then raise wb_ready_i: the 4 groups are popped in order with grp_idx 0,1,2,3; the 5th is accepted the cycle after the first pop.
- Steady streaming:
  - Stimulus: continuous push and pop at count=1 for 10 cycles.
  - Response: count stays 1, one group per cycle, pointers wrap past DEPTH with no loss or reorder.
- Error and flush:
  - Stimulus: push with lane_ready_i=0xFE, vm_i=1, vl_i=8.
  - Response: err_o=1 next cycle with wb_we_o=0xFE. flush_i then gives err_o=0, wb_valid_o=0, and no done_o even when last=1.
- Async reset:
  - Stimulus: assert rst between clock edges while 3 groups are queued.
  - Response: wb_valid_o=0 and grp_ready_o=1 immediately, without waiting for a clock edge; no done_o after release.
